// File: rtl/morse_seq_buffer_if.sv
// Bundles the character input and buffer status/snapshot signals of morse_seq_buffer.
// The master modport drives characters and commands; the slave modport is the buffer.
interface morse_seq_buffer_if #(
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_CHAR = 5,
  parameter int DEPTH         = 16
);
  localparam int CHAR_W = SYM_W * SYMS_PER_CHAR;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                    char_valid;
  logic [CHAR_W-1:0]       char_code;
  logic                    backspace;
  logic                    enter;
  logic                    char_ready;
  logic [CNT_W-1:0]        wr_count;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic [DEPTH*CHAR_W-1:0] o_sequence;
  logic [CNT_W-1:0]        o_count;
  logic                    o_valid;

  modport master (
    output char_valid, char_code, backspace, enter,
    input  char_ready, wr_count, full, empty, overflow, o_sequence, o_count, o_valid
  );

  modport slave (
    input  char_valid, char_code, backspace, enter,
    output char_ready, wr_count, full, empty, overflow, o_sequence, o_count, o_valid
  );
endinterface

// File: rtl/morse_seq_buffer.sv
// Working buffer of encoded Morse characters with backspace and an edge-triggered
// commit to a stable snapshot. Slot 0 sits at the MSB; unused slots are all-ones.
module morse_seq_buffer #(
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_CHAR = 5,
  parameter int DEPTH         = 16
) (
  input  logic              clk,
  input  logic              reset,
  morse_seq_buffer_if.slave bus
);
  localparam int CHAR_W = SYM_W * SYMS_PER_CHAR;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BUF_W  = DEPTH * CHAR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CHAR_W-1:0] r_slot [DEPTH];
  logic [CNT_W-1:0]  r_wr_count;
  logic [CNT_W-1:0]  r_o_count;
  logic [BUF_W-1:0]  r_seq;
  logic              r_overflow;
  logic              r_o_valid;
  logic              r_enter_d;

  logic [BUF_W-1:0]  w_packed;
  logic [CNT_W-1:0]  w_last;
  logic              w_commit;
  logic              w_full;
  logic              w_empty;
  logic              w_code_empty;

  // enter_d resets low, so an enter already high at reset release commits once.
  assign w_commit     = bus.enter & ~r_enter_d;
  assign w_full       = (r_wr_count == FULL_CNT);
  assign w_empty      = (r_wr_count == '0);
  assign w_code_empty = &bus.char_code;
  assign w_last       = r_wr_count - 1'b1;

  always_comb begin
    w_packed = '1;
    for (int i = 0; i < DEPTH; i++) begin
      w_packed[(DEPTH-i)*CHAR_W-1 -: CHAR_W] = r_slot[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '1;
      end
      r_wr_count <= '0;
      r_o_count  <= '0;
      r_seq      <= '1;
      r_overflow <= 1'b0;
      r_o_valid  <= 1'b0;
      r_enter_d  <= 1'b0;
    end else begin
      r_enter_d <= bus.enter;
      r_o_valid <= w_commit;
      if (w_commit) begin
        r_seq      <= w_packed;
        r_o_count  <= r_wr_count;
        r_wr_count <= '0;
        r_overflow <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          r_slot[i] <= '1;
        end
      end else if (bus.backspace) begin
        if (!w_empty) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == w_last) r_slot[i] <= '1;
          end
          r_wr_count <= w_last;
        end
      end else if (bus.char_valid && !w_code_empty) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == r_wr_count) r_slot[i] <= bus.char_code;
          end
          r_wr_count <= r_wr_count + 1'b1;
        end
      end
    end
  end

  assign bus.char_ready = ~w_full;
  assign bus.wr_count   = r_wr_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.o_sequence = r_seq;
  assign bus.o_count    = r_o_count;
  assign bus.o_valid    = r_o_valid;
endmodule
